// File: rtl/watchdog_pkg.sv
// Shared types and helpers for the watchdog block.
package watchdog_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      BITE = 2'd2
   } wdt_state_t;

   // Width of the reset-pulse down-counter; it must be able to hold the pulse length.
   function automatic int rst_cnt_width(input int pulse);
      return (pulse < 1) ? 1 : $clog2(pulse + 1);
   endfunction

endpackage

// File: rtl/watchdog_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a slow clock treated as data.
// Emits one clk-wide tick per rise of async_in; reusable for any low-speed clock consumer.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic tick
);

   logic s1;
   logic s2;
   logic s3;

   // s1/s2 resolve metastability, s3 holds the previous synchronized level.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;

endmodule

// File: rtl/watchdog.sv
// Watchdog timer: counts wdt_clk rises in the clk domain and requests a system
// reset when software fails to kick in time.
// Optional macro WATCHDOG_WINDOW_EN: kicks arriving too early also cause a bite.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disarmed; count frozen, kick and ticks ignored
// RUN   | armed; ticks decrement count, kick reloads from timeout
// BITE  | wdt_reset held high for RST_PULSE clk cycles, then back to IDLE
module watchdog
   import watchdog_pkg::*;
#(
   parameter int TIMEOUT_W       = 16,
   parameter int DEFAULT_TIMEOUT = 1000,
   parameter int WARN_MARGIN     = 8,
   parameter int RST_PULSE       = 16,
   parameter int WINDOW_MIN      = 500
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wdt_clk,
   input  logic                 enable,
   input  logic                 kick,
   input  logic                 load_valid,
   input  logic [TIMEOUT_W-1:0] load_value,
   output logic [TIMEOUT_W-1:0] count,
   output logic                 warn,
   output logic                 wdt_reset,
   output logic                 expired
);

   localparam int                   RST_W       = rst_cnt_width(RST_PULSE);
   localparam logic [RST_W-1:0]     PULSE_LOAD  = RST_W'(RST_PULSE - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_RST = TIMEOUT_W'(DEFAULT_TIMEOUT);
   localparam logic [TIMEOUT_W-1:0] WARN_LVL    = TIMEOUT_W'(WARN_MARGIN);

   if (RST_PULSE < 1 || WINDOW_MIN < 0) begin : g_bad_params
      $error("watchdog: RST_PULSE must be >= 1 and WINDOW_MIN must be >= 0");
   end

   wdt_state_t           state_q;
   wdt_state_t           state_d;
   logic [TIMEOUT_W-1:0] count_q;
   logic [TIMEOUT_W-1:0] count_d;
   logic [TIMEOUT_W-1:0] timeout_q;
   logic [RST_W-1:0]     pulse_q;
   logic [RST_W-1:0]     pulse_d;
   logic                 expired_q;
   logic                 expired_d;
   logic                 tick;
   logic                 kick_early;

   sync_edge u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .async_in (wdt_clk),
      .tick     (tick)
   );

`ifdef WATCHDOG_WINDOW_EN
   // Early when count > timeout - WINDOW_MIN; rearranged to avoid underflow.
   assign kick_early = ({1'b0, count_q} + (TIMEOUT_W + 1)'(WINDOW_MIN)) > {1'b0, timeout_q};
`else
   assign kick_early = 1'b0;
`endif

   // Timeout register; zero would bite on the very first tick, so it is stored as one.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= TIMEOUT_RST;
      end else if (load_valid) begin
         timeout_q <= (load_value == '0) ? TIMEOUT_W'(1) : load_value;
      end
   end

   // State, remaining ticks, reset-pulse timer and the sticky bite flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= TIMEOUT_RST;
         pulse_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pulse_q   <= pulse_d;
         expired_q <= expired_d;
      end
   end

   // Next-state logic; kick has priority over a coincident tick.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pulse_d   = pulse_q;
      expired_d = expired_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               count_d = timeout_q;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (kick) begin
               if (kick_early) begin
                  state_d   = BITE;
                  pulse_d   = PULSE_LOAD;
                  expired_d = 1'b1;
               end else begin
                  count_d = timeout_q;
               end
            end else if (tick) begin
               if (count_q == '0) begin
                  state_d   = BITE;
                  pulse_d   = PULSE_LOAD;
                  expired_d = 1'b1;
               end else begin
                  count_d = count_q - TIMEOUT_W'(1);
               end
            end
         end
         BITE: begin
            if (pulse_q == '0) begin
               state_d = IDLE;
            end else begin
               pulse_d = pulse_q - RST_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign count     = count_q;
   assign warn      = (state_q == RUN) && (count_q <= WARN_LVL);
   assign wdt_reset = (state_q == BITE);
   assign expired   = expired_q;

endmodule

// File: tb/tb_watchdog.sv
// Directed bench for watchdog: stimulus pushes expected outputs into a queue
// tagged with the cycle they apply to; a monitor compares them on falling edges.
module tb_watchdog;

   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wdt_clk = 1'b0;
   logic          enable = 1'b0;
   logic          kick = 1'b0;
   logic          load_valid = 1'b0;
   logic [TW-1:0] load_value = '0;
   logic [TW-1:0] count;
   logic          warn;
   logic          wdt_reset;
   logic          expired;

   watchdog #(
      .TIMEOUT_W       (TW),
      .DEFAULT_TIMEOUT (4),
      .WARN_MARGIN     (8),
      .RST_PULSE       (16),
      .WINDOW_MIN      (500)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wdt_clk    (wdt_clk),
      .enable     (enable),
      .kick       (kick),
      .load_valid (load_valid),
      .load_value (load_value),
      .count      (count),
      .warn       (warn),
      .wdt_reset  (wdt_reset),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      string         name;
      logic [TW-1:0] count;
      logic          warn;
      logic          rst;
      logic          expd;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_x = sb.pop_front();
         checks++;
         if (mon_x.cyc != cyc) begin
            errors++;
            $display("FAIL %s expectation for cycle %0d reached only at cycle %0d",
                     mon_x.name, mon_x.cyc, cyc);
         end else if (count !== mon_x.count || warn !== mon_x.warn ||
                      wdt_reset !== mon_x.rst || expired !== mon_x.expd) begin
            errors++;
            $display("FAIL %s got count=%0d warn=%b wdt_reset=%b expired=%b, required count=%0d warn=%b wdt_reset=%b expired=%b",
                     mon_x.name, count, warn, wdt_reset, expired,
                     mon_x.count, mon_x.warn, mon_x.rst, mon_x.expd);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [TW-1:0] c,
                             input logic w, input logic r, input logic e);
      exp_t x;
      x.cyc   = cyc;
      x.name  = name;
      x.count = c;
      x.warn  = w;
      x.rst   = r;
      x.expd  = e;
      sb.push_back(x);
   endtask

   // One wdt_clk period (3 clk high, 4 low); the count reacts on the 3rd edge.
   task automatic wdt_tick(input bit kick_with, input bit chk, input string name,
                           input logic [TW-1:0] c, input logic w, input logic r,
                           input logic e);
      wdt_clk = 1'b1;
      step(2);
      if (kick_with) kick = 1'b1;
      step(1);
      kick = 1'b0;
      if (chk) expect_out(name, c, w, r, e);
      wdt_clk = 1'b0;
      step(4);
   endtask

   task automatic do_kick();
      kick = 1'b1;
      step(1);
      kick = 1'b0;
   endtask

   task automatic do_load(input logic [TW-1:0] v);
      load_value = v;
      load_valid = 1'b1;
      step(1);
      load_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      step(2);
      expect_out("reset", 4, 0, 0, 0);
      reset  = 1'b0;
      enable = 1'b1;
      step(1);
      expect_out("arm", 4, 1, 0, 0);
`ifndef WATCHDOG_WINDOW_EN
      wdt_tick(0, 1, "dec3", 3, 1, 0, 0);
      wdt_tick(0, 1, "dec2", 2, 1, 0, 0);
      wdt_tick(0, 1, "dec1", 1, 1, 0, 0);
      wdt_tick(0, 1, "dec0", 0, 1, 0, 0);
      wdt_tick(0, 1, "bite", 0, 0, 1, 1);
      enable = 1'b0;
      step(11);
      expect_out("bite_hold16", 0, 0, 1, 1);
      step(1);
      expect_out("bite_end", 0, 0, 0, 1);
      step(1);
      expect_out("idle_disabled", 0, 0, 0, 1);
      enable = 1'b1;
      step(1);
      expect_out("rearm", 4, 1, 0, 1);

      for (int k = 0; k < 3; k++) begin
         wdt_tick(0, 1, "kloop3", 3, 1, 0, 1);
         wdt_tick(0, 1, "kloop2", 2, 1, 0, 1);
         wdt_tick(0, 1, "kloop1", 1, 1, 0, 1);
         do_kick();
         expect_out("kloop_reload", 4, 1, 0, 1);
      end

      wdt_tick(0, 1, "coin_pre3", 3, 1, 0, 1);
      wdt_tick(0, 1, "coin_pre2", 2, 1, 0, 1);
      wdt_tick(1, 1, "coincident", 4, 1, 0, 1);

      wdt_tick(0, 1, "load_pre", 3, 1, 0, 1);
      do_load(10);
      expect_out("load_no_effect", 3, 1, 0, 1);
      wdt_tick(0, 1, "load_dec", 2, 1, 0, 1);
      do_kick();
      expect_out("load_kick10", 10, 0, 0, 1);
      do_load(0);
      expect_out("load0_hold", 10, 0, 0, 1);
      do_kick();
      expect_out("load0_kick", 1, 1, 0, 1);

      wdt_tick(0, 1, "pre_bite", 0, 1, 0, 1);
      wdt_tick(0, 1, "bite2", 0, 0, 1, 1);
      reset = 1'b1;
      step(1);
      expect_out("mid_bite_reset", 4, 0, 0, 0);
      reset  = 1'b0;
      enable = 1'b0;
      step(1);
      expect_out("idle_after_reset", 4, 0, 0, 0);
      do_kick();
      expect_out("idle_kick_ignored", 4, 0, 0, 0);
      wdt_tick(0, 1, "idle_tick_ignored", 4, 0, 0, 0);
      enable = 1'b1;
      step(1);
      expect_out("arm2", 4, 1, 0, 0);
      wdt_tick(0, 1, "run_dec", 3, 1, 0, 0);
      enable = 1'b0;
      step(1);
      expect_out("disable", 3, 0, 0, 0);
`else
      do_load(1000);
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      step(1);
      expect_out("win_arm", 1000, 0, 0, 0);
      repeat (100) wdt_tick(0, 0, "", 0, 0, 0, 0);
      expect_out("win_900", 900, 0, 0, 0);
      do_kick();
      expect_out("win_early_bite", 900, 0, 1, 1);
      step(15);
      expect_out("win_bite_hold16", 900, 0, 1, 1);
      step(1);
      expect_out("win_bite_end", 900, 0, 0, 1);
      step(1);
      expect_out("win_rearm", 1000, 0, 0, 1);
      repeat (600) wdt_tick(0, 0, "", 0, 0, 0, 0);
      expect_out("win_400", 400, 0, 0, 1);
      do_kick();
      expect_out("win_legal_kick", 1000, 0, 0, 1);
`endif
      step(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain %0d expectations left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
